// File: rtl/qspi_master.sv
// Quad-SPI initiator (CPOL=0/CPHA=0): one start runs CS-low frame of cmd, optional TX, dummy, optional RX.
// Latency: cs/busy/first nibble from the accept edge; first SCLK rise CLK_DIV clocks later.
// Backpressure: none; tx_data must be valid when tx_ready pulses, start is ignored while busy.
// Ports: clk/reset_n; start, cmd, tx_len, rx_len request; tx_data/tx_ready payload in;
//        rx_data/rx_valid payload out; busy, done status; cs, sclk, mosi_d0/miso_d1/d2/d3 link.
module qspi_master #(
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] tx_len,
    input  logic [7:0] rx_len,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       cs,
    output logic       sclk,
    inout  wire        mosi_d0,
    inout  wire        miso_d1,
    inout  wire        d2,
    inout  wire        d3
);

    localparam int             HCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
    localparam logic [7:0]     DC_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_TX, S_DUMMY, S_RX, S_END, S_RECOVER
    } state_t;

    state_t         state;
    logic [HCW-1:0] hc;        // half-period counter
    logic [7:0]     bit_cnt;   // SCLK cycles done in the current byte / dummy phase
    logic [7:0]     byte_cnt;  // bytes remaining including the current one
    logic           oe;
    logic [3:0]     dout;
    logic [3:0]     cmd_lo;
    logic [3:0]     tx_lo;
    logic [3:0]     rx_hi;
    logic [3:0]     rx_lo;
    logic           rx_pend;
    logic           do_tx;
    logic           do_rx;
    logic [7:0]     rx_len_q;
    logic [3:0]     lines;
    logic           tick;

    assign mosi_d0 = oe ? dout[0] : 1'bz;
    assign miso_d1 = oe ? dout[1] : 1'bz;
    assign d2      = oe ? dout[2] : 1'bz;
    assign d3      = oe ? dout[3] : 1'bz;
    assign lines   = {d3, d2, miso_d1, mosi_d0};
    assign tick    = (hc == HC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hc       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            oe       <= 1'b0;
            dout     <= '0;
            cmd_lo   <= '0;
            tx_lo    <= '0;
            rx_hi    <= '0;
            rx_lo    <= '0;
            rx_pend  <= 1'b0;
            do_tx    <= 1'b0;
            do_rx    <= 1'b0;
            rx_len_q <= '0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            // Byte assembled at the low-nibble rise is presented one clock later.
            if (rx_pend) begin
                rx_valid <= 1'b1;
                rx_data  <= {rx_hi, rx_lo};
                rx_pend  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    hc <= '0;
                    if (start) begin
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        oe       <= 1'b1;
                        dout     <= cmd[7:4];
                        cmd_lo   <= cmd[3:0];
                        do_tx    <= cmd[7] && (tx_len != 8'd0);
                        do_rx    <= cmd[6] && (rx_len != 8'd0);
                        byte_cnt <= tx_len;
                        rx_len_q <= rx_len;
                        bit_cnt  <= '0;
                        state    <= S_CMD;
                    end
                end

                S_CMD, S_TX, S_DUMMY, S_RX: begin
                    if (!tick) begin
                        hc <= hc + 1'b1;
                    end else begin
                        hc   <= '0;
                        sclk <= ~sclk;
                        if (!sclk) begin
                            // Rising edge: sample only during read-back.
                            if (state == S_RX) begin
                                if (bit_cnt == 8'd0) begin
                                    rx_hi <= lines;
                                end else begin
                                    rx_lo   <= lines;
                                    rx_pend <= 1'b1;
                                end
                            end
                        end else if (state == S_CMD || state == S_TX) begin
                            // Falling edge closes one SCLK cycle and launches the next nibble.
                            if (bit_cnt == 8'd0) begin
                                dout    <= (state == S_CMD) ? cmd_lo : tx_lo;
                                bit_cnt <= 8'd1;
                            end else if ((state == S_CMD) ? do_tx : (byte_cnt > 8'd1)) begin
                                if (state == S_TX) begin
                                    byte_cnt <= byte_cnt - 8'd1;
                                end
                                tx_ready <= 1'b1;
                                dout     <= tx_data[7:4];
                                tx_lo    <= tx_data[3:0];
                                bit_cnt  <= '0;
                                state    <= S_TX;
                            end else begin
                                oe       <= 1'b0;
                                bit_cnt  <= '0;
                                byte_cnt <= rx_len_q;
                                if (!do_rx) begin
                                    state <= S_END;
                                end else if (DUMMY_CYCLES > 0) begin
                                    state <= S_DUMMY;
                                end else begin
                                    state <= S_RX;
                                end
                            end
                        end else if (state == S_DUMMY) begin
                            if (bit_cnt == DC_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_RX;
                            end else begin
                                bit_cnt <= bit_cnt + 8'd1;
                            end
                        end else begin
                            if (bit_cnt == 8'd0) begin
                                bit_cnt <= 8'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (byte_cnt > 8'd1) begin
                                    byte_cnt <= byte_cnt - 8'd1;
                                end else begin
                                    state <= S_END;
                                end
                            end
                        end
                    end
                end

                // CS held low for one half-period after the final fall.
                S_END: begin
                    if (tick) begin
                        hc      <= '0;
                        cs      <= 1'b1;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_RECOVER;
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end

                // CS-high minimum: two half-periods before the next accept.
                S_RECOVER: begin
                    if (tick) begin
                        hc <= '0;
                        if (bit_cnt[0]) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            bit_cnt <= 8'd1;
                        end
                    end else begin
                        hc <= hc + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_master.sv
// Directed bench for qspi_master with CLK_DIV=2, DUMMY_CYCLES=2 and a simple quad target model.
// Lines have pull-ups, so a released bus reads 4'hF.
// A negedge monitor collects nibbles, strobes and timing for the linear check sequence.
module tb_qspi_master;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] cmd;
    logic [7:0] tx_len;
    logic [7:0] rx_len;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       cs;
    logic       sclk;
    wire        mosi_d0, miso_d1, d2, d3;
    wire  [3:0] lines = {d3, d2, miso_d1, mosi_d0};

    int checks = 0;
    int errors = 0;

    // Target model state
    logic       tgt_oe = 1'b0;
    logic [3:0] tgt_nib = 4'h0;
    logic [3:0] tgt_nibs [8];
    int         tgt_first = 1000;
    int         tgt_n = 0;
    int         tgt_idx = 0;

    logic [7:0] tx_arr [4];
    logic [1:0] tx_idx = 2'd0;
    assign tx_data = tx_arr[tx_idx];

    pullup (mosi_d0);
    pullup (miso_d1);
    pullup (d2);
    pullup (d3);
    assign mosi_d0 = tgt_oe ? tgt_nib[0] : 1'bz;
    assign miso_d1 = tgt_oe ? tgt_nib[1] : 1'bz;
    assign d2      = tgt_oe ? tgt_nib[2] : 1'bz;
    assign d3      = tgt_oe ? tgt_nib[3] : 1'bz;

    qspi_master #(.CLK_DIV(2), .DUMMY_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd),
        .tx_len(tx_len), .rx_len(rx_len), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .cs(cs), .sclk(sclk), .mosi_d0(mosi_d0), .miso_d1(miso_d1), .d2(d2), .d3(d3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor
    logic        clr = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [63:0] nib_w = '0;
    logic [31:0] rx_w = '0;
    logic [3:0]  lines_at_done = '0;
    int cyc = 0, busy_cnt = 0, cs_low_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    int txr_cnt = 0, rx_cnt = 0, done_cnt = 0;
    int cs_fall_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0;
    int fall2_cyc = 0, txr_cyc = 0, done_cyc = 0, rxv_gap = 0;

    always @(negedge clk) begin
        if (clr) begin
            nib_w = '0; rx_w = '0; lines_at_done = '0;
            cyc = 0; busy_cnt = 0; cs_low_cnt = 0; rise_cnt = 0; fall_cnt = 0;
            txr_cnt = 0; rx_cnt = 0; done_cnt = 0;
            cs_fall_cyc = 0; first_rise_cyc = 0; last_rise_cyc = 0; last_fall_cyc = 0;
            fall2_cyc = 0; txr_cyc = 0; done_cyc = 0; rxv_gap = 0;
            tgt_idx = 0; tgt_oe = 1'b0; tx_idx = 2'd0;
        end else begin
            cyc++;
            if (busy) busy_cnt++;
            if (!cs) cs_low_cnt++;
            if (!cs && prev_cs) cs_fall_cyc = cyc;
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                nib_w = {nib_w[59:0], lines};
                if (rise_cnt == 1) first_rise_cyc = cyc;
                last_rise_cyc = cyc;
            end
            if (!sclk && prev_sclk) begin
                fall_cnt++;
                if (fall_cnt == 2) fall2_cyc = cyc;
                last_fall_cyc = cyc;
                if (fall_cnt >= tgt_first && tgt_idx < tgt_n) begin
                    tgt_nib = tgt_nibs[tgt_idx];
                    tgt_oe  = 1'b1;
                    tgt_idx++;
                end
            end
            if (tx_ready) begin
                txr_cnt++;
                if (txr_cnt == 1) txr_cyc = cyc;
                tx_idx++;
            end
            if (rx_valid) begin
                rx_cnt++;
                rx_w = {rx_w[23:0], rx_data};
                rxv_gap = cyc - last_rise_cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                lines_at_done = lines;
            end
            if (cs) tgt_oe = 1'b0;
        end
        prev_cs = cs;
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] c, input logic [7:0] tl, input logic [7:0] rl);
        @(posedge clk); #1;
        cmd = c; tx_len = tl; rx_len = rl; start = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; cmd = '0; tx_len = '0; rx_len = '0;
        tx_arr[0] = 8'h00; tx_arr[1] = 8'h00; tx_arr[2] = 8'h00; tx_arr[3] = 8'h00;
        for (int i = 0; i < 8; i++) tgt_nibs[i] = 4'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cs", 64'(cs), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tx_ready", 64'(tx_ready), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'h00);
        chk("rst_lines_z", 64'(lines), 64'hF);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Command only
        tgt_first = 1000; tgt_n = 0;
        start_frame(8'h50, 8'd0, 8'd0);
        wait_idle("f1_timeout");
        chk("f1_rises", 64'(rise_cnt), 64'd2);
        chk("f1_nibbles", nib_w, 64'h50);
        chk("f1_tx_ready", 64'(txr_cnt), 64'd0);
        chk("f1_rx_valid", 64'(rx_cnt), 64'd0);
        chk("f1_done_cnt", 64'(done_cnt), 64'd1);
        chk("f1_busy_clks", 64'(busy_cnt), 64'd14);
        chk("f1_cs_low_clks", 64'(cs_low_cnt), 64'd10);
        chk("f1_first_rise", 64'(first_rise_cyc - cs_fall_cyc), 64'd2);
        chk("f1_done_delay", 64'(done_cyc - last_fall_cyc), 64'd2);
        chk("f1_released", 64'(lines_at_done), 64'hF);

        // Write two bytes
        tx_arr[0] = 8'hA5; tx_arr[1] = 8'h3C;
        start_frame(8'h80, 8'd2, 8'd0);
        wait_idle("f2_timeout");
        chk("f2_rises", 64'(rise_cnt), 64'd6);
        chk("f2_nibbles", nib_w, 64'h80A53C);
        chk("f2_tx_ready", 64'(txr_cnt), 64'd2);
        chk("f2_txr_at_fall2", 64'(txr_cyc - fall2_cyc), 64'd0);
        chk("f2_released", 64'(lines_at_done), 64'hF);
        chk("f2_done_cnt", 64'(done_cnt), 64'd1);

        // Read one byte after dummy cycles
        tgt_first = 4; tgt_n = 2; tgt_nibs[0] = 4'hD; tgt_nibs[1] = 4'h7;
        start_frame(8'h51, 8'd0, 8'd1);
        wait_idle("f3_timeout");
        chk("f3_rises", 64'(rise_cnt), 64'd6);
        chk("f3_nibbles", nib_w, 64'h51FFD7);
        chk("f3_rx_cnt", 64'(rx_cnt), 64'd1);
        chk("f3_rx_data", 64'(rx_w), 64'hD7);
        chk("f3_rxv_gap", 64'(rxv_gap), 64'd1);
        chk("f3_tx_ready", 64'(txr_cnt), 64'd0);

        // Write one, read two
        tx_arr[0] = 8'h3C;
        tgt_first = 6; tgt_n = 4;
        tgt_nibs[0] = 4'h1; tgt_nibs[1] = 4'h2; tgt_nibs[2] = 4'h3; tgt_nibs[3] = 4'h4;
        start_frame(8'hC1, 8'd1, 8'd2);
        wait_idle("f4_timeout");
        chk("f4_rises", 64'(rise_cnt), 64'd10);
        chk("f4_nibbles", nib_w, 64'hC13CFF1234);
        chk("f4_rx_cnt", 64'(rx_cnt), 64'd2);
        chk("f4_rx_data", 64'(rx_w), 64'h1234);
        chk("f4_tx_ready", 64'(txr_cnt), 64'd1);

        // Reset in the middle of TX byte 1
        tgt_first = 1000; tgt_n = 0;
        tx_arr[0] = 8'hA5; tx_arr[1] = 8'h3C;
        start_frame(8'h80, 8'd2, 8'd0);
        begin
            int n;
            n = 0;
            while (rise_cnt < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("f5_reached_tx", 64'(rise_cnt >= 3), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("f5_rst_cs", 64'(cs), 64'd1);
        chk("f5_rst_sclk", 64'(sclk), 64'd0);
        chk("f5_rst_busy", 64'(busy), 64'd0);
        chk("f5_rst_lines_z", 64'(lines), 64'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_frame(8'h50, 8'd0, 8'd0);
        wait_idle("f5_timeout");
        chk("f5_rises", 64'(rise_cnt), 64'd2);
        chk("f5_nibbles", nib_w, 64'h50);
        chk("f5_done_cnt", 64'(done_cnt), 64'd1);

        // Start while busy is ignored; rx_len=0 skips dummy and read
        start_frame(8'h41, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; cmd = 8'hC1; tx_len = 8'd5; rx_len = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("f6_timeout");
        chk("f6_rises", 64'(rise_cnt), 64'd2);
        chk("f6_nibbles", nib_w, 64'h41);
        chk("f6_tx_ready", 64'(txr_cnt), 64'd0);
        chk("f6_rx_cnt", 64'(rx_cnt), 64'd0);
        chk("f6_done_cnt", 64'(done_cnt), 64'd1);
        repeat (3) @(negedge clk);
        chk("f6_stays_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
